// File: rtl/i2c_master_read_byte_if.sv
// Bus between the byte receive stage, the transaction controller above it
// and the bit-level read/write stage below it.
// master: the byte receive stage's view. slave: the surrounding logic's view.
interface i2c_master_read_byte_if #(
  parameter int NUM_BITS = 8
);
  // transaction controller side
  logic                start;
  logic                send_ack;
  logic                busy;
  logic [NUM_BITS-1:0] byte_data;
  logic                byte_valid;
  logic                timeout_error;

  // bit stage side
  logic                bit_read_req;
  logic                bit_read_ready;
  logic                bit_data;
  logic                bit_write_req;
  logic                bit_write_value;
  logic                bit_write_ready;
  logic                bit_timeout;

  modport master (
    input  start,
    input  send_ack,
    output busy,
    output byte_data,
    output byte_valid,
    output timeout_error,
    output bit_read_req,
    input  bit_read_ready,
    input  bit_data,
    output bit_write_req,
    output bit_write_value,
    input  bit_write_ready,
    input  bit_timeout
  );

  modport slave (
    output start,
    output send_ack,
    input  busy,
    input  byte_data,
    input  byte_valid,
    input  timeout_error,
    input  bit_read_req,
    output bit_read_ready,
    output bit_data,
    input  bit_write_req,
    input  bit_write_value,
    output bit_write_ready,
    output bit_timeout
  );
endinterface

// File: rtl/i2c_master_read_byte.sv
// Byte receive stage of the I2C master. Issues NUM_BITS bit reads to the
// bit stage, assembles them MSB-first, then writes one ACK/NACK bit and
// hands the byte upward with a one-cycle valid pulse. A clock-stretch
// timeout reported by the bit stage aborts the byte with an error pulse.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for start; busy low
// READ_REQ   | bit_read_req pulse for the next data bit
// READ_WAIT  | waiting for bit_read_ready; shift in bit or abort on timeout
// ACK_REQ    | bit_write_req pulse carrying ACK (0) / NACK (1)
// ACK_WAIT   | waiting for bit_write_ready; finish or abort on timeout
// DONE       | byte_data presented with the byte_valid pulse
module i2c_master_read_byte #(
  parameter int NUM_BITS = 8
) (
  input logic                    clk,
  input logic                    reset_n,
  i2c_master_read_byte_if.master bus
);

  localparam int CNT_W = $clog2(NUM_BITS + 1);
  // Count value held while the final bit is outstanding.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_READ_REQ  = 3'd1;
  localparam logic [2:0] ST_READ_WAIT = 3'd2;
  localparam logic [2:0] ST_ACK_REQ   = 3'd3;
  localparam logic [2:0] ST_ACK_WAIT  = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [CNT_W-1:0]    bit_cnt;
  logic [NUM_BITS-1:0] shift_reg;
  logic [NUM_BITS-1:0] data_q;
  logic                write_value_q;
  logic                timeout_q;

  logic                start_ok;
  logic                read_hit;
  logic                write_hit;
  logic                read_good;
  logic                write_good;
  logic                abort;

  // A start landing in the IDLE cycle that carries a timeout pulse is the
  // controller's request racing the abort; it must be reissued, so drop it.
  assign start_ok   = bus.start && (state == ST_IDLE) && !timeout_q;

  // Ready strobes only count in the matching wait state.
  assign read_hit   = bus.bit_read_ready  && (state == ST_READ_WAIT);
  assign write_hit  = bus.bit_write_ready && (state == ST_ACK_WAIT);
  assign read_good  = read_hit  && !bus.bit_timeout;
  assign write_good = write_hit && !bus.bit_timeout;
  assign abort      = (read_hit || write_hit) && bus.bit_timeout;

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          state_nxt = ST_READ_REQ;
        end
      end
      ST_READ_REQ: begin
        state_nxt = ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        if (read_hit) begin
          if (bus.bit_timeout) begin
            state_nxt = ST_IDLE;
          end else if (bit_cnt == CNT_LAST) begin
            state_nxt = ST_ACK_REQ;
          end else begin
            state_nxt = ST_READ_REQ;
          end
        end
      end
      ST_ACK_REQ: begin
        state_nxt = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: begin
        if (write_hit) begin
          state_nxt = bus.bit_timeout ? ST_IDLE : ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Shift register and bit counter: cleared per byte, advanced per good bit.
  // The counter tops out at NUM_BITS, which its width always holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (start_ok) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (read_good) begin
      shift_reg <= (shift_reg << 1) | NUM_BITS'(bus.bit_data);
      bit_cnt   <= bit_cnt + CNT_ONE;
    end
  end

  // ACK/NACK value latched at start; idles at NACK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_value_q <= 1'b1;
    end else if (start_ok) begin
      write_value_q <= ~bus.send_ack;
    end
  end

  // Output byte loads as DONE is entered so it is valid alongside byte_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (write_good) begin
      data_q <= shift_reg;
    end
  end

  // Timeout pulse, coincident with the return to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= abort;
    end
  end

  assign bus.busy            = (state != ST_IDLE);
  assign bus.bit_read_req    = (state == ST_READ_REQ);
  assign bus.bit_write_req   = (state == ST_ACK_REQ);
  assign bus.byte_valid      = (state == ST_DONE);
  assign bus.byte_data       = data_q;
  assign bus.bit_write_value = write_value_q;
  assign bus.timeout_error   = timeout_q;

endmodule

// File: tb/tb_i2c_master_read_byte.sv
// Bench for the I2C byte receive stage: a randomized bit-stage responder,
// an event-level reference model compared every cycle, and per-byte
// transaction checks against hand-known expectations.
module tb_i2c_master_read_byte;

  localparam int NB = 8;

  logic clk = 1'b0;
  logic reset_n;

  i2c_master_read_byte_if #(.NUM_BITS(NB)) bus ();

  i2c_master_read_byte #(.NUM_BITS(NB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- responder configuration / bookkeeping ----------------
  logic [NB-1:0] cfg_bits     = '0;
  int            cfg_tout_bit = 0;
  bit            cfg_tout_ack = 0;
  bit            cfg_spur     = 0;
  int            cfg_lmax     = 0;
  int            rd_cnt       = 0;
  int            wr_cnt       = 0;
  int            rd_base      = 0;
  logic          wval_seen    = 1'b1;

  // Bit-stage responder: answers each request after a random delay with the
  // configured bit values, and optionally throws in stray ready strobes.
  initial begin : responder
    bit r_seen, w_seen, rd_pend, wr_pend, drove;
    int rd_dly, wr_dly, k;
    rd_pend = 0; wr_pend = 0; rd_dly = 0; wr_dly = 0; k = 0;
    bus.bit_read_ready  = 1'b0;
    bus.bit_write_ready = 1'b0;
    bus.bit_timeout     = 1'b0;
    bus.bit_data        = 1'b0;
    forever begin
      @(negedge clk);
      r_seen = (bus.bit_read_req === 1'b1);
      w_seen = (bus.bit_write_req === 1'b1);
      if (r_seen) rd_cnt++;
      if (w_seen) begin
        wr_cnt++;
        wval_seen = bus.bit_write_value;
      end
      @(posedge clk);
      #1;
      bus.bit_read_ready  = 1'b0;
      bus.bit_write_ready = 1'b0;
      bus.bit_timeout     = 1'b0;
      bus.bit_data        = 1'($urandom_range(1, 0));
      drove = 0;
      if (!reset_n) begin
        rd_pend = 0;
        wr_pend = 0;
      end else begin
        if (r_seen) begin
          rd_pend = 1;
          k = rd_cnt - rd_base;
          rd_dly = $urandom_range(cfg_lmax, 0);
        end
        if (w_seen) begin
          wr_pend = 1;
          wr_dly = $urandom_range(cfg_lmax, 0);
        end
        if (rd_pend) begin
          if (rd_dly == 0) begin
            bus.bit_read_ready = 1'b1;
            bus.bit_data       = (k >= 1 && k <= NB) ? cfg_bits[NB-k] : 1'b0;
            bus.bit_timeout    = (k == cfg_tout_bit);
            rd_pend = 0;
            drove   = 1;
          end else begin
            rd_dly--;
          end
        end
        if (wr_pend) begin
          if (wr_dly == 0) begin
            bus.bit_write_ready = 1'b1;
            bus.bit_timeout     = cfg_tout_ack;
            wr_pend = 0;
            drove   = 1;
          end else begin
            wr_dly--;
          end
        end
        if (cfg_spur) begin
          if (!rd_pend && !bus.bit_read_ready && $urandom_range(3, 0) == 0)
            bus.bit_read_ready = 1'b1;
          if (!wr_pend && !bus.bit_write_ready && $urandom_range(3, 0) == 0)
            bus.bit_write_ready = 1'b1;
          if (!drove) bus.bit_timeout = 1'($urandom_range(1, 0));
        end
      end
    end
  end

  // ---------------- reference model (event level) ----------------
  // e_* are the required outputs for the current cycle. After checking,
  // the next cycle's expectations follow from the protocol's cause/effect
  // rules: a request follows one cycle after start or after a good bit, a
  // result pulse follows one cycle after the deciding ready strobe.
  logic          e_busy, e_rreq, e_wreq, e_valid, e_tout, e_wval;
  logic [NB-1:0] e_data, m_acc;
  int            m_bits;
  bit            m_wait_r, m_wait_w;
  int            valid_cnt = 0;
  int            tout_cnt  = 0;
  int            last_valid_cyc = 0;
  logic [NB-1:0] last_valid_data = '0;

  always @(negedge clk) begin : model_cmp
    logic          n_busy, n_rreq, n_wreq, n_valid, n_tout, n_wval;
    logic [NB-1:0] n_data;
    if (!reset_n) begin
      e_busy = 0; e_rreq = 0; e_wreq = 0; e_valid = 0; e_tout = 0; e_wval = 1;
      e_data = '0; m_acc = '0; m_bits = 0; m_wait_r = 0; m_wait_w = 0;
    end
    chk("busy",            bus.busy,            e_busy);
    chk("bit_read_req",    bus.bit_read_req,    e_rreq);
    chk("bit_write_req",   bus.bit_write_req,   e_wreq);
    chk("byte_valid",      bus.byte_valid,      e_valid);
    chk("timeout_error",   bus.timeout_error,   e_tout);
    chk("bit_write_value", bus.bit_write_value, e_wval);
    chk("byte_data",       bus.byte_data,       e_data);
    if (reset_n) begin
      if (bus.byte_valid === 1'b1) begin
        valid_cnt++;
        last_valid_cyc  = cyc;
        last_valid_data = bus.byte_data;
      end
      if (bus.timeout_error === 1'b1) tout_cnt++;

      n_busy = e_busy; n_rreq = 0; n_wreq = 0; n_valid = 0; n_tout = 0;
      n_wval = e_wval; n_data = e_data;
      if (e_valid) n_busy = 0;
      if (!e_busy && !e_tout && bus.start) begin
        n_busy = 1; n_rreq = 1; n_wval = !bus.send_ack; m_bits = 0; m_acc = '0;
      end
      if (m_wait_r && bus.bit_read_ready) begin
        m_wait_r = 0;
        if (bus.bit_timeout) begin
          n_tout = 1; n_busy = 0;
        end else begin
          m_acc = {m_acc[NB-2:0], bus.bit_data};
          m_bits++;
          if (m_bits == NB) n_wreq = 1;
          else              n_rreq = 1;
        end
      end
      if (m_wait_w && bus.bit_write_ready) begin
        m_wait_w = 0;
        if (bus.bit_timeout) begin
          n_tout = 1; n_busy = 0;
        end else begin
          n_valid = 1; n_data = m_acc;
        end
      end
      if (e_rreq) m_wait_r = 1;
      if (e_wreq) m_wait_w = 1;
      e_busy = n_busy; e_rreq = n_rreq; e_wreq = n_wreq; e_valid = n_valid;
      e_tout = n_tout; e_wval = n_wval; e_data = n_data;
    end
  end

  // ---------------- transaction driver ----------------
  logic [NB-1:0] last_good = '0;

  // Called at posedge+1 of an idle cycle; returns at posedge+1 of an idle cycle.
  task automatic run_tx(input bit ack, input logic [NB-1:0] bits, input int tout_bit,
                        input bit tout_ack, input bit spur, input int lmax,
                        input int exp_lat, input string tag);
    int r0, w0, v0, t0, s_cyc;
    bit done, fail_exp;
    cfg_bits = bits; cfg_tout_bit = tout_bit; cfg_tout_ack = tout_ack;
    cfg_spur = spur; cfg_lmax = lmax;
    rd_base = rd_cnt;
    r0 = rd_cnt; w0 = wr_cnt; v0 = valid_cnt; t0 = tout_cnt;
    fail_exp = (tout_bit != 0) || tout_ack;
    bus.start = 1'b1;
    bus.send_ack = ack;
    s_cyc = cyc;
    done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(posedge clk);
      #1;
      bus.start    = spur && (e_busy || e_tout) && ($urandom_range(4, 0) == 0);
      bus.send_ack = 1'($urandom_range(1, 0));
      @(negedge clk);
      #1;
      done = (valid_cnt != v0) || (tout_cnt != t0);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, " finished"}, 32'(done), 1);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " reads"},    rd_cnt - r0,    (tout_bit != 0) ? tout_bit : NB);
    chk({tag, " writes"},   wr_cnt - w0,    (tout_bit != 0) ? 0 : 1);
    chk({tag, " valids"},   valid_cnt - v0, fail_exp ? 0 : 1);
    chk({tag, " timeouts"}, tout_cnt - t0,  fail_exp ? 1 : 0);
    if (tout_bit == 0) chk({tag, " ack value"}, 32'(wval_seen), 32'(!ack));
    if (!fail_exp) begin
      chk({tag, " byte"}, last_valid_data, bits);
      last_good = bits;
      if (exp_lat > 0) chk({tag, " latency"}, last_valid_cyc - s_cyc, exp_lat);
    end else begin
      chk({tag, " byte held"}, bus.byte_data, last_good);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit found;
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.send_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset busy",            bus.busy,            0);
    chk("reset byte_data",       bus.byte_data,       0);
    chk("reset byte_valid",      bus.byte_valid,      0);
    chk("reset timeout_error",   bus.timeout_error,   0);
    chk("reset bit_read_req",    bus.bit_read_req,    0);
    chk("reset bit_write_req",   bus.bit_write_req,   0);
    chk("reset bit_write_value", bus.bit_write_value, 1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_tx(1'b1, 8'hA5, 0, 1'b0, 1'b0, 0, 19, "ack_a5");
    chk("ack_a5 literal", last_valid_data, 8'hA5);
    run_tx(1'b0, 8'hFF, 0, 1'b0, 1'b0, 0, 19, "nack_ff");
    run_tx(1'b1, 8'h5E, 4, 1'b0, 1'b0, 2, 0, "tout_bit4");
    chk("tout_bit4 keeps ff", bus.byte_data, 8'hFF);
    run_tx(1'b1, 8'h33, 0, 1'b1, 1'b0, 3, 0, "tout_ack");
    run_tx(1'b1, 8'h69, 0, 1'b0, 1'b1, 20, 0, "spur_69");

    for (int n = 0; n < 20; n++) begin
      int tb_bit;
      bit ta;
      tb_bit = ($urandom_range(3, 0) == 0) ? $urandom_range(NB, 1) : 0;
      ta     = (tb_bit == 0) && ($urandom_range(4, 0) == 0);
      run_tx(1'($urandom_range(1, 0)), NB'($urandom), tb_bit, ta, 1'b1,
             $urandom_range(20, 0), 0, "random");
    end

    // Reset while waiting on the fifth bit.
    cfg_bits = 8'h96; cfg_tout_bit = 0; cfg_tout_ack = 0; cfg_spur = 0; cfg_lmax = 4;
    rd_base = rd_cnt;
    bus.start = 1'b1;
    bus.send_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      #1;
      found = (rd_cnt - rd_base) >= 5;
    end
    chk("reached bit5", 32'(found), 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst busy",            bus.busy,            0);
    chk("midrst byte_data",       bus.byte_data,       0);
    chk("midrst byte_valid",      bus.byte_valid,      0);
    chk("midrst timeout_error",   bus.timeout_error,   0);
    chk("midrst bit_read_req",    bus.bit_read_req,    0);
    chk("midrst bit_write_req",   bus.bit_write_req,   0);
    chk("midrst bit_write_value", bus.bit_write_value, 1);
    last_good = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_tx(1'b1, 8'h3C, 0, 1'b0, 1'b0, 0, 19, "post_reset_3c");
    chk("post_reset literal", last_valid_data, 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
